// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction word layout, opcodes and fetch FSM state encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned CNT_W  = 3;

    localparam logic [DATA_W-1:0] NOP_INSN = 16'h0000;

    localparam logic [OP_W-1:0] OP_NOP  = 5'b00000;
    localparam logic [OP_W-1:0] OP_HALT = 5'b00001;
    localparam logic [OP_W-1:0] OP_BEQ  = 5'b00010;
    localparam logic [OP_W-1:0] OP_BNE  = 5'b00011;
    localparam logic [OP_W-1:0] OP_JMP  = 5'b00100;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_FLUSH  = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

    function automatic logic is_halt(input logic [DATA_W-1:0] insn);
        return insn[DATA_W-1 -: OP_W] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: control inputs, instruction memory port and the instruction register outputs.
interface fetch_ctrl_if;
    import cpu_pkg::*;

    logic              start;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic [ADDR_W-1:0] imem_addr;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic              halted;

    modport master (
        input  start, stall, branch_taken, branch_addr, imem_rdata,
        output imem_addr, pc, ir, ir_valid, halted
    );

    modport slave (
        output start, stall, branch_taken, branch_addr, imem_rdata,
        input  imem_addr, pc, ir, ir_valid, halted
    );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the pc into an async-read imem, loads ir, inserts
// branch bubbles and drains the pipeline after HALT.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned BUBBLES = 1,
    parameter int unsigned DRAIN   = 3
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              redirect;

    assign redirect = bus.branch_taken &&
                      (state_q == ST_RUN || state_q == ST_FLUSH || state_q == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pc_q     <= '0;
            ir_q     <= NOP_INSN;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    // Branch redirect outranks stall and fetch in every active state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        valid_d  = valid_q;
        halted_d = halted_q;

        if (redirect) begin
            pc_d    = bus.branch_addr;
            ir_d    = NOP_INSN;
            valid_d = 1'b0;
            cnt_d   = CNT_W'(BUBBLES - 1);
            state_d = (BUBBLES > 1) ? ST_FLUSH : ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pc_d    = '0;
                    ir_d    = NOP_INSN;
                    valid_d = 1'b0;
                    if (bus.start) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!bus.stall) begin
                        ir_d    = bus.imem_rdata;
                        valid_d = 1'b1;
                        if (is_halt(bus.imem_rdata)) begin
                            cnt_d = CNT_W'(DRAIN);
                            if (DRAIN == 0) begin
                                state_d  = ST_HALTED;
                                halted_d = 1'b1;
                            end else begin
                                state_d = ST_DRAIN;
                            end
                        end else begin
                            pc_d = pc_q + 8'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    ir_d    = NOP_INSN;
                    valid_d = 1'b0;
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    ir_d    = NOP_INSN;
                    valid_d = 1'b0;
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d    = '0;
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_HALTED: begin
                    ir_d     = NOP_INSN;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    if (bus.start) begin
                        halted_d = 1'b0;
                        pc_d     = '0;
                        state_d  = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = valid_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with BUBBLES=2, DRAIN=3 against a 256-word async-read memory.
module tb_fetch_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [15:0] mem [0:255];

    localparam logic [15:0] HALT_W = 16'h0800;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.BUBBLES(2), .DRAIN(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_rdata = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pc(input string tag, input logic [7:0] exp);
        checks++;
        assert (bus.pc === exp && bus.imem_addr === exp) else begin
            errors++;
            $error("FAIL %s pc observed=%h imem_addr observed=%h expected=%h", tag, bus.pc, bus.imem_addr, exp);
        end
    endtask

    task automatic chk_ir(input string tag, input logic [15:0] exp, input logic exp_v);
        checks++;
        assert (bus.ir === exp && bus.ir_valid === exp_v) else begin
            errors++;
            $error("FAIL %s ir/valid observed=%h/%b expected=%h/%b", tag, bus.ir, bus.ir_valid, exp, exp_v);
        end
    endtask

    task automatic chk_halted(input string tag, input logic exp);
        checks++;
        assert (bus.halted === exp) else begin
            errors++;
            $error("FAIL %s halted observed=%b expected=%b", tag, bus.halted, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[17] = HALT_W;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_addr = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        chk_pc("reset_pc", 8'h00);
        chk_ir("reset_ir", 16'h0000, 1'b0);
        chk_halted("reset_halted", 1'b0);
        bus.stall = 1'b1;
        tick();
        bus.stall = 1'b0;
        chk_pc("idle_hold", 8'h00);

        // Straight-line fetch of words 0..3.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_pc("start_pc", 8'h00);
        chk_ir("start_ir", 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_ir("line_ir", 16'h1000 + 16'(i), 1'b1);
            chk_pc("line_pc", 8'(i + 1));
        end
        tick();
        chk_pc("pre_stall_pc", 8'h05);

        // Two stall cycles at pc=5.
        bus.stall = 1'b1;
        tick();
        chk_pc("stall1_pc", 8'h05);
        chk_ir("stall1_ir", 16'h1004, 1'b1);
        tick();
        chk_pc("stall2_pc", 8'h05);
        chk_ir("stall2_ir", 16'h1004, 1'b1);
        bus.stall = 1'b0;
        tick();
        chk_ir("resume_ir", 16'h1005, 1'b1);
        chk_pc("resume_pc", 8'h06);

        // Start while running has no effect.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_pc("start_ignored", 8'h07);
        tick();
        tick();
        chk_pc("at9_pc", 8'h09);

        // Taken branch to 0x0B: two bubbles.
        bus.branch_taken = 1'b1;
        bus.branch_addr = 8'h0B;
        tick();
        bus.branch_taken = 1'b0;
        chk_ir("bubble1_ir", 16'h0000, 1'b0);
        chk_pc("bubble1_pc", 8'h0B);
        bus.stall = 1'b1;
        tick();
        bus.stall = 1'b0;
        chk_ir("bubble2_ir", 16'h0000, 1'b0);
        chk_pc("bubble2_pc", 8'h0B);
        tick();
        chk_ir("target_ir", 16'h100B, 1'b1);
        chk_pc("target_pc", 8'h0C);

        // Stall and branch together: branch wins.
        bus.stall = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_addr = 8'h40;
        tick();
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        chk_pc("stall_branch_pc", 8'h40);
        chk_ir("stall_branch_ir", 16'h0000, 1'b0);
        tick();
        tick();
        chk_ir("sb_target_ir", 16'h1040, 1'b1);
        chk_pc("sb_target_pc", 8'h41);

        // Wrap past 0xFF.
        bus.branch_taken = 1'b1;
        bus.branch_addr = 8'hFE;
        tick();
        bus.branch_taken = 1'b0;
        tick();
        tick();
        chk_ir("wrap_fe_ir", 16'h10FE, 1'b1);
        chk_pc("wrap_ff_pc", 8'hFF);
        tick();
        chk_ir("wrap_ff_ir", 16'h10FF, 1'b1);
        chk_pc("wrap_pc", 8'h00);

        // Fetch up to the HALT at address 17, then drain.
        for (int i = 0; i < 17; i++) tick();
        chk_pc("pre_halt_pc", 8'h11);
        tick();
        chk_ir("halt_ir", HALT_W, 1'b1);
        chk_pc("halt_pc", 8'h11);
        chk_halted("halt_not_yet", 1'b0);
        tick();
        chk_ir("drain1_ir", 16'h0000, 1'b0);
        chk_halted("drain1_halted", 1'b0);
        tick();
        chk_ir("drain2_ir", 16'h0000, 1'b0);
        chk_halted("drain2_halted", 1'b0);
        tick();
        chk_ir("drain3_ir", 16'h0000, 1'b0);
        chk_halted("drain3_halted", 1'b1);
        chk_pc("halted_pc", 8'h11);
        tick();
        chk_halted("halted_hold", 1'b1);
        chk_pc("halted_pc_hold", 8'h11);

        // Restart from HALTED.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_halted("restart_halted", 1'b0);
        chk_pc("restart_pc", 8'h00);
        tick();
        chk_ir("restart_ir", 16'h1000, 1'b1);
        chk_pc("restart_pc1", 8'h01);

        // Reset in the middle of DRAIN.
        bus.branch_taken = 1'b1;
        bus.branch_addr = 8'h11;
        tick();
        bus.branch_taken = 1'b0;
        tick();
        tick();
        chk_ir("halt2_ir", HALT_W, 1'b1);
        tick();
        chk_ir("drain_mid_ir", 16'h0000, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_pc("drain_reset_pc", 8'h00);
        chk_ir("drain_reset_ir", 16'h0000, 1'b0);
        chk_halted("drain_reset_halted", 1'b0);
        tick();
        tick();
        tick();
        chk_pc("post_reset_idle_pc", 8'h00);
        chk_halted("post_reset_idle_halted", 1'b0);
        chk_ir("post_reset_idle_ir", 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
